table_fsm_ctrl: RTL and testbench

Parametrised, table-driven successor to the team's hard-wired 5-flip-flop benchmark controllers: a single state register steps through a runtime-programmable transition/output table instead of fixed gate logic. Its CLR input plays the role of the all-next-state clear input in the fixed benchmarks. It adds watchdog, miss and error monitors, and serves as a scalable sequential benchmark and a drop-in control FSM in the fmcad test designs.

---
 rtl/table_fsm_ctrl.sv | 111 +++++++++++
 tb/tb_table_fsm_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/table_fsm_ctrl.sv
// rtl/table_fsm_ctrl.sv - table-driven control FSM with watchdog, miss and error monitors
// One state register walks a runtime-programmed {state, class} -> {next, out} table.
module table_fsm_ctrl #(
  parameter int ST_W        = 5,
  parameter int N_STATES    = 32,
  parameter int CLS_W       = 3,
  parameter int OUT_W       = 19,
  parameter int WD_LIMIT    = 255,
  parameter int RESET_STATE = 0
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [CLS_W-1:0]       cls,
  input  logic                   wr_en,
  input  logic [ST_W+CLS_W-1:0]  wr_addr,
  input  logic [ST_W-1:0]        wr_next,
  input  logic [OUT_W-1:0]       wr_out,
  output logic [ST_W-1:0]        state,
  output logic [OUT_W-1:0]       out,
  output logic                   wd_trip,
  output logic                   miss,
  output logic                   err
);

  localparam int DEPTH = 1 << (ST_W + CLS_W);
  localparam int WD_W  = $clog2(WD_LIMIT + 1);
  localparam logic [ST_W:0]   N_ST   = N_STATES[ST_W:0];
  localparam logic [ST_W-1:0] RST_ST = RESET_STATE[ST_W-1:0];
  localparam logic [WD_W-1:0] WD_MAX = WD_LIMIT[WD_W-1:0];

  // Data fields carry no reset; only the valid bits decide visibility.
  logic [ST_W+OUT_W-1:0] mem [0:DEPTH-1];
  logic [DEPTH-1:0]      valid;

  logic [ST_W+CLS_W-1:0] rd_idx;
  logic                  rd_valid;
  logic [ST_W-1:0]       rd_next;
  logic [OUT_W-1:0]      rd_out;

  logic [WD_W-1:0]  cnt, cnt_n;
  logic [ST_W-1:0]  state_n;
  logic [OUT_W-1:0] out_n;
  logic             trip_n, miss_n, err_n;

  always_ff @(posedge ck) begin
    if (wr_en) mem[wr_addr] <= {wr_next, wr_out};
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst)        valid          <= '0;
    else if (wr_en) valid[wr_addr] <= 1'b1;
  end

  // Lookup uses pre-edge contents, so a same-edge write is seen only next step.
  assign rd_idx   = {state, cls};
  assign rd_valid = valid[rd_idx];
  assign {rd_next, rd_out} = mem[rd_idx];

  always_comb begin
    state_n = state;
    out_n   = out;
    miss_n  = miss;
    err_n   = err;
    cnt_n   = cnt;
    trip_n  = wd_trip;
    if (clr) begin
      state_n = RST_ST;
      out_n   = '0;
      miss_n  = 1'b0;
      err_n   = 1'b0;
      cnt_n   = '0;
      trip_n  = 1'b0;
    end else if (en) begin
      if (!rd_valid) begin
        out_n  = '0;
        miss_n = 1'b1;
      end else if ({1'b0, rd_next} >= N_ST) begin
        out_n = '0;
        err_n = 1'b1;
      end else begin
        state_n = rd_next;
        out_n   = rd_out;
      end
      // Held steps (including miss/err) count toward the watchdog.
      if (state_n == state) cnt_n = (cnt == WD_MAX) ? WD_MAX : cnt + 1'b1;
      else                  cnt_n = '0;
      trip_n = (cnt_n == WD_MAX);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= RST_ST;
      out     <= '0;
      miss    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      wd_trip <= 1'b0;
    end else begin
      state   <= state_n;
      out     <= out_n;
      miss    <= miss_n;
      err     <= err_n;
      cnt     <= cnt_n;
      wd_trip <= trip_n;
    end
  end

endmodule

// File: tb/tb_table_fsm_ctrl.sv
// tb/tb_table_fsm_ctrl.sv - self-checking bench for table_fsm_ctrl
// Vector table with a scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_table_fsm_ctrl;

  logic        ck = 1'b0;
  logic        rst, clr, en, wr_en;
  logic [2:0]  cls;
  logic [7:0]  wr_addr;
  logic [4:0]  wr_next;
  logic [18:0] wr_out;
  logic [4:0]  state;
  logic [18:0] out_q;
  logic        wd_trip, miss, err;

  table_fsm_ctrl #(
    .ST_W(5), .N_STATES(20), .CLS_W(3), .OUT_W(19), .WD_LIMIT(4), .RESET_STATE(0)
  ) dut (
    .ck(ck), .rst(rst), .clr(clr), .en(en), .cls(cls),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_next(wr_next), .wr_out(wr_out),
    .state(state), .out(out_q), .wd_trip(wd_trip), .miss(miss), .err(err)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic clr; logic en; logic [2:0] cls;
    logic we; logic [4:0] ws; logic [2:0] wc; logic [4:0] wn; logic [18:0] wo;
    logic [4:0] st; logic [18:0] o; logic trip; logic miss; logic err;
  } vec_t;

  typedef struct {
    logic [4:0] st; logic [18:0] o; logic trip; logic miss; logic err; int id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_part1;

  function automatic vec_t mk(input logic c, input logic e, input logic [2:0] k,
                              input logic we, input logic [4:0] ws, input logic [2:0] wc,
                              input logic [4:0] wn, input logic [18:0] wo,
                              input logic [4:0] st, input logic [18:0] o,
                              input logic t, input logic m, input logic r);
    vec_t x;
    x.clr = c; x.en = e; x.cls = k; x.we = we; x.ws = ws; x.wc = wc; x.wn = wn; x.wo = wo;
    x.st = st; x.o = o; x.trip = t; x.miss = m; x.err = r;
    return x;
  endfunction

  task automatic check_now(input string name, input exp_t e);
    checks++;
    if (state !== e.st || out_q !== e.o || wd_trip !== e.trip || miss !== e.miss || err !== e.err) begin
      failures++;
      $display("FAIL %s: got state=%0d out=%h trip=%b miss=%b err=%b, want state=%0d out=%h trip=%b miss=%b err=%b",
               name, state, out_q, wd_trip, miss, err, e.st, e.o, e.trip, e.miss, e.err);
    end
  endtask

  task automatic apply(input vec_t x, input int id);
    exp_t e;
    @(negedge ck);
    clr = x.clr; en = x.en; cls = x.cls;
    wr_en = x.we; wr_addr = {x.ws, x.wc}; wr_next = x.wn; wr_out = x.wo;
    e.st = x.st; e.o = x.o; e.trip = x.trip; e.miss = x.miss; e.err = x.err; e.id = id;
    sb.push_back(e);
    @(posedge ck);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      check_now($sformatf("vec%0d", e.id), e);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.st = 0; z.o = 0; z.trip = 0; z.miss = 0; z.err = 0; z.id = -1;
    return z;
  endfunction

  initial begin
    // clr en cls | we ws wc wn wo | st out trip miss err
    vecs.push_back(mk(0,0,0, 1,0,1,3,'h00005,  0,'h00000, 0,0,0)); // program {0,1}
    vecs.push_back(mk(0,0,0, 1,3,2,0,'h40000,  0,'h00000, 0,0,0)); // program {3,2}
    vecs.push_back(mk(0,1,1, 0,0,0,0,0,        3,'h00005, 0,0,0));
    vecs.push_back(mk(0,1,2, 0,0,0,0,0,        0,'h40000, 0,0,0));
    vecs.push_back(mk(0,1,7, 0,0,0,0,0,        0,'h00000, 0,1,0)); // miss
    vecs.push_back(mk(1,0,0, 0,0,0,0,0,        0,'h00000, 0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,25,'h00123, 0,'h00000, 0,0,0)); // next out of range
    vecs.push_back(mk(0,1,0, 0,0,0,0,0,        0,'h00000, 0,0,1)); // err
    vecs.push_back(mk(1,0,0, 0,0,0,0,0,        0,'h00000, 0,0,0));
    vecs.push_back(mk(0,1,1, 1,0,1,5,'h00007,  3,'h00005, 0,0,0)); // collision: old entry used
    vecs.push_back(mk(0,1,2, 0,0,0,0,0,        0,'h40000, 0,0,0));
    vecs.push_back(mk(0,1,1, 0,0,0,0,0,        5,'h00007, 0,0,0)); // new entry now seen
    vecs.push_back(mk(0,0,0, 1,5,0,2,'h00011,  5,'h00007, 0,0,0));
    vecs.push_back(mk(0,0,0, 1,2,0,2,'h00022,  5,'h00007, 0,0,0)); // self loop on 2
    vecs.push_back(mk(0,1,0, 1,2,3,1,'h00033,  2,'h00011, 0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0,0,        2,'h00022, 0,0,0)); // count 1
    vecs.push_back(mk(0,0,0, 0,0,0,0,0,        2,'h00022, 0,0,0)); // idle holds
    vecs.push_back(mk(0,1,0, 0,0,0,0,0,        2,'h00022, 0,0,0)); // count 2
    vecs.push_back(mk(0,1,0, 0,0,0,0,0,        2,'h00022, 0,0,0)); // count 3
    vecs.push_back(mk(0,0,0, 0,0,0,0,0,        2,'h00022, 0,0,0));
    vecs.push_back(mk(0,1,0, 0,0,0,0,0,        2,'h00022, 1,0,0)); // count 4: trip
    vecs.push_back(mk(0,1,0, 0,0,0,0,0,        2,'h00022, 1,0,0)); // saturated
    vecs.push_back(mk(0,1,3, 1,1,4,6,'h00044,  1,'h00033, 0,0,0)); // leave: trip clears
    vecs.push_back(mk(1,1,4, 1,0,2,9,'h00099,  0,'h00000, 0,0,0)); // clr beats en, write lands
    vecs.push_back(mk(0,1,2, 0,0,0,0,0,        9,'h00099, 0,0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0,0,        0,'h00000, 0,0,0));
    vecs.push_back(mk(0,1,1, 0,0,0,0,0,        5,'h00007, 0,0,0)); // table retained
    vecs.push_back(mk(0,0,0, 1,5,1,7,'h00077,  5,'h00007, 0,0,0));
    vecs.push_back(mk(0,1,1, 0,0,0,0,0,        7,'h00077, 0,0,0));
    n_part1 = vecs.size();
    // after the mid-run reset
    vecs.push_back(mk(0,1,1, 0,0,0,0,0,        0,'h00000, 0,1,0)); // {0,1} invalidated
    vecs.push_back(mk(0,1,6, 0,0,0,0,0,        0,'h00000, 0,1,0)); // write under reset dropped
    vecs.push_back(mk(0,0,0, 1,0,3,4,'h00001,  0,'h00000, 0,1,0));
    vecs.push_back(mk(0,1,3, 0,0,0,0,0,        4,'h00001, 0,1,0)); // miss stays sticky

    rst = 1'b1; clr = 1'b0; en = 1'b0; cls = '0;
    wr_en = 1'b0; wr_addr = '0; wr_next = '0; wr_out = '0;
    repeat (2) @(posedge ck);
    #1;
    check_now("reset_defaults", zero_exp());
    @(negedge ck);
    rst = 1'b0;

    for (int i = 0; i < n_part1; i++) apply(vecs[i], i);

    // Asynchronous reset mid-cycle while a write and a step are pending.
    @(negedge ck);
    en = 1'b1; cls = 3'd1;
    wr_en = 1'b1; wr_addr = {5'd0, 3'd6}; wr_next = 5'd2; wr_out = 19'h00abc;
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset", zero_exp());
    @(posedge ck);
    #1;
    check_now("reset_held", zero_exp());
    @(negedge ck);
    rst = 1'b0; en = 1'b0; wr_en = 1'b0;

    for (int i = n_part1; i < vecs.size(); i++) apply(vecs[i], i);

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
